// File: rtl/mesi_isc_cpu_agent.sv
// CPU-port agent for mesi_isc: direct-mapped MESI line table, request FSM on the main bus and snoop FSM on the
// coherence bus. cpu_done_o is asserted in the cycle after a hit is accepted (accept cycle + done cycle).
module mesi_isc_cpu_agent #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int LINE_IDX_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_i,
  input  logic                      cpu_wr_i,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr_i,
  output logic                      cpu_ready_o,
  output logic                      cpu_done_o,
  output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
  output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
  input  logic                      mbus_ack_i,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  output logic                      cbus_ack_o,
  output logic                      proto_err_o
);

  localparam int NUM_LINES = 2 ** LINE_IDX_W;
  localparam int TAG_W     = ADDR_WIDTH - LINE_IDX_W;

  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_NOP      = MBUS_CMD_WIDTH'(0);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR       = MBUS_CMD_WIDTH'(1);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD       = MBUS_CMD_WIDTH'(2);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR_BROAD = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD_BROAD = MBUS_CMD_WIDTH'(4);

  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_NOP      = CBUS_CMD_WIDTH'(0);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_RD    = CBUS_CMD_WIDTH'(4);

  typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_t;
  typedef enum logic [2:0] {R_IDLE, R_BROAD, R_WAIT_EN, R_MEM, R_DONE} req_state_t;
  typedef enum logic [1:0] {S_IDLE, S_WB, S_ACK, S_GAP} snp_state_t;

  mesi_t                    line_state_q [NUM_LINES];
  mesi_t                    line_state_d [NUM_LINES];
  logic [TAG_W-1:0]         line_tag_q   [NUM_LINES];
  logic [TAG_W-1:0]         line_tag_d   [NUM_LINES];

  req_state_t               req_state_q, req_state_d;
  logic                     req_wr_q, req_wr_d;
  logic [ADDR_WIDTH-1:0]    req_addr_q, req_addr_d;

  snp_state_t               snp_state_q, snp_state_d;
  logic [ADDR_WIDTH-1:0]    snp_addr_q, snp_addr_d;
  logic                     snp_rd_q, snp_rd_d;
  logic                     wb_issued_q, wb_issued_d;

  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_q, mbus_cmd_d;
  logic [ADDR_WIDTH-1:0]     mbus_addr_q, mbus_addr_d;
  logic                      proto_err_q, proto_err_d;

  // Table lookups for the CPU and coherence addresses
  logic [LINE_IDX_W-1:0] cpu_idx, cbus_idx;
  logic [TAG_W-1:0]      cpu_tag, cbus_tag;
  mesi_t                 cpu_line, cbus_line;
  logic                  cpu_hit, cbus_hit, accept, en_match;

  assign cpu_idx   = cpu_addr_i[LINE_IDX_W-1:0];
  assign cpu_tag   = cpu_addr_i[ADDR_WIDTH-1:LINE_IDX_W];
  assign cpu_line  = line_state_q[cpu_idx];
  assign cpu_hit   = (cpu_line != MESI_I) && (line_tag_q[cpu_idx] == cpu_tag);
  assign cbus_idx  = cbus_addr_i[LINE_IDX_W-1:0];
  assign cbus_tag  = cbus_addr_i[ADDR_WIDTH-1:LINE_IDX_W];
  assign cbus_line = line_state_q[cbus_idx];
  assign cbus_hit  = (cbus_line != MESI_I) && (line_tag_q[cbus_idx] == cbus_tag);

  assign cpu_ready_o = !rst && (req_state_q == R_IDLE) && (snp_state_q == S_IDLE) && (cbus_cmd_i == CBUS_NOP);
  assign accept      = cpu_req_i && cpu_ready_o;
  assign en_match    = (req_state_q == R_WAIT_EN) && (cbus_addr_i == req_addr_q) &&
                       ((cbus_cmd_i == CBUS_EN_WR && req_wr_q) || (cbus_cmd_i == CBUS_EN_RD && !req_wr_q));

  // Per-FSM requests into the shared table and main-bus registers
  logic                  req_we, snp_we;
  logic [LINE_IDX_W-1:0] req_we_idx, snp_we_idx;
  logic [TAG_W-1:0]      req_we_tag;
  mesi_t                 req_we_state, snp_we_state;
  logic                  req_mb_load, req_mb_clr, snp_mb_load, snp_mb_clr;
  logic [MBUS_CMD_WIDTH-1:0] req_mb_cmd;
  logic [ADDR_WIDTH-1:0]     req_mb_addr;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    req_state_d  = req_state_q;
    req_wr_d     = req_wr_q;
    req_addr_d   = req_addr_q;
    req_we       = 1'b0;
    req_we_idx   = cpu_idx;
    req_we_tag   = cpu_tag;
    req_we_state = MESI_M;
    req_mb_load  = 1'b0;
    req_mb_clr   = 1'b0;
    req_mb_cmd   = MBUS_NOP;
    req_mb_addr  = req_addr_q;
    unique case (req_state_q)
      R_IDLE: if (accept) begin
        req_addr_d = cpu_addr_i;
        req_wr_d   = cpu_wr_i;
        if (!cpu_wr_i && cpu_hit) begin
          req_state_d = R_DONE;
        end else if (cpu_wr_i && cpu_hit && (cpu_line == MESI_M || cpu_line == MESI_E)) begin
          req_state_d = R_DONE;
          req_we      = 1'b1;
        end else begin
          req_state_d = R_BROAD;
          req_mb_load = 1'b1;
          req_mb_cmd  = cpu_wr_i ? MBUS_WR_BROAD : MBUS_RD_BROAD;
          req_mb_addr = cpu_addr_i;
        end
      end
      R_BROAD: if (mbus_ack_i) begin
        req_state_d = R_WAIT_EN;
        req_mb_clr  = 1'b1;
      end
      R_WAIT_EN: if (snp_state_q == S_IDLE && en_match) begin
        req_state_d = R_MEM;
        req_mb_load = 1'b1;
        req_mb_cmd  = req_wr_q ? MBUS_WR : MBUS_RD;
      end
      R_MEM: if (mbus_ack_i) begin
        req_state_d  = R_DONE;
        req_mb_clr   = 1'b1;
        req_we       = 1'b1;
        req_we_idx   = req_addr_q[LINE_IDX_W-1:0];
        req_we_tag   = req_addr_q[ADDR_WIDTH-1:LINE_IDX_W];
        req_we_state = req_wr_q ? MESI_M : MESI_S;
      end
      R_DONE:  req_state_d = R_IDLE;
      default: req_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    snp_state_d  = snp_state_q;
    snp_addr_d   = snp_addr_q;
    snp_rd_d     = snp_rd_q;
    wb_issued_d  = wb_issued_q;
    proto_err_d  = proto_err_q;
    snp_we       = 1'b0;
    snp_we_idx   = cbus_idx;
    snp_we_state = MESI_I;
    snp_mb_load  = 1'b0;
    snp_mb_clr   = 1'b0;
    unique case (snp_state_q)
      S_IDLE: if (cbus_cmd_i != CBUS_NOP) begin
        snp_state_d = S_ACK;
        snp_addr_d  = cbus_addr_i;
        case (cbus_cmd_i)
          CBUS_WR_SNOOP: if (cbus_hit) begin
            if (cbus_line == MESI_M) begin
              snp_state_d = S_WB;
              snp_rd_d    = 1'b0;
            end else begin
              snp_we = 1'b1;
            end
          end
          CBUS_RD_SNOOP: if (cbus_hit) begin
            if (cbus_line == MESI_M) begin
              snp_state_d = S_WB;
              snp_rd_d    = 1'b1;
            end else if (cbus_line == MESI_E) begin
              snp_we       = 1'b1;
              snp_we_state = MESI_S;
            end
          end
          CBUS_EN_WR, CBUS_EN_RD: if (!en_match) proto_err_d = 1'b1;
          default: proto_err_d = 1'b1;
        endcase
      end
      // The write-back holds off while the request FSM owns the main bus
      S_WB: if (!wb_issued_q) begin
        if (req_state_q != R_BROAD && req_state_q != R_MEM) begin
          snp_mb_load = 1'b1;
          wb_issued_d = 1'b1;
        end
      end else if (mbus_ack_i) begin
        snp_mb_clr   = 1'b1;
        wb_issued_d  = 1'b0;
        snp_we       = 1'b1;
        snp_we_idx   = snp_addr_q[LINE_IDX_W-1:0];
        snp_we_state = snp_rd_q ? MESI_S : MESI_I;
        snp_state_d  = S_ACK;
      end
      S_ACK:   snp_state_d = S_GAP;
      S_GAP:   snp_state_d = S_IDLE;
      default: snp_state_d = S_IDLE;
    endcase
  end

  // Merge table and main-bus updates; the snoop side is applied last so it wins
  always_comb begin
    line_state_d = line_state_q;
    line_tag_d   = line_tag_q;
    mbus_cmd_d   = mbus_cmd_q;
    mbus_addr_d  = mbus_addr_q;
    if (req_we) begin
      line_state_d[req_we_idx] = req_we_state;
      line_tag_d[req_we_idx]   = req_we_tag;
    end
    if (snp_we) line_state_d[snp_we_idx] = snp_we_state;
    if (req_mb_clr || snp_mb_clr) mbus_cmd_d = MBUS_NOP;
    if (req_mb_load) begin
      mbus_cmd_d  = req_mb_cmd;
      mbus_addr_d = req_mb_addr;
    end
    if (snp_mb_load) begin
      mbus_cmd_d  = MBUS_WR;
      mbus_addr_d = snp_addr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the line table is small and must come up all-Invalid, so each entry is reset like any other flop.
      for (int i = 0; i < NUM_LINES; i++) begin
        line_state_q[i] <= MESI_I;
        line_tag_q[i]   <= '0;
      end
      req_state_q <= R_IDLE;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      snp_state_q <= S_IDLE;
      snp_addr_q  <= '0;
      snp_rd_q    <= 1'b0;
      wb_issued_q <= 1'b0;
      mbus_cmd_q  <= MBUS_NOP;
      mbus_addr_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      line_state_q <= line_state_d;
      line_tag_q   <= line_tag_d;
      req_state_q  <= req_state_d;
      req_wr_q     <= req_wr_d;
      req_addr_q   <= req_addr_d;
      snp_state_q  <= snp_state_d;
      snp_addr_q   <= snp_addr_d;
      snp_rd_q     <= snp_rd_d;
      wb_issued_q  <= wb_issued_d;
      mbus_cmd_q   <= mbus_cmd_d;
      mbus_addr_q  <= mbus_addr_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign cpu_done_o  = (req_state_q == R_DONE);
  assign cbus_ack_o  = (snp_state_q == S_ACK);
  assign mbus_cmd_o  = mbus_cmd_q;
  assign mbus_addr_o = mbus_addr_q;
  assign proto_err_o = proto_err_q;

endmodule
